// File: rtl/redmule_obi2axi_bridge.sv
// OBI data-port to single-beat AXI4 bridge for the RedMulE tile.
// One outstanding transaction; reads and writes serialised by an FSM.
package redmule_tile_pkg;

  localparam int AXI_DATA_ID_W = 2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
  } core_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } core_data_rsp_t;

  typedef struct packed {
    logic [AXI_DATA_ID_W-1:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } axi_aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_DATA_ID_W-1:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_DATA_ID_W-1:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } axi_ar_t;

  typedef struct packed {
    logic [AXI_DATA_ID_W-1:0] id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } core_axi_data_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } core_axi_data_rsp_t;

endpackage

module redmule_obi2axi_bridge
  import redmule_tile_pkg::*;
#(
  parameter type obi_req_t = core_data_req_t,
  parameter type obi_rsp_t = core_data_rsp_t,
  parameter type axi_req_t = core_axi_data_req_t,
  parameter type axi_rsp_t = core_axi_data_rsp_t,
  parameter logic [AXI_DATA_ID_W-1:0] AXI_ID = '0,
  parameter logic [3:0] AXI_CACHE = 4'b0010
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output axi_req_t axi_req_o,
  input  axi_rsp_t axi_rsp_i
);

  typedef enum logic [2:0] {
    IDLE, WR, WB, RD_A, RD_R, RSP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [0:0]  aid_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        gnt;
  logic        aw_valid, w_valid;
  logic        aw_hs, w_hs;
  logic        unused_rsp;

  assign gnt = obi_req_i.req & (state_q == IDLE) & ~rst_i;
  assign aw_valid = (state_q == WR) & ~aw_done_q;
  assign w_valid  = (state_q == WR) & ~w_done_q;
  assign aw_hs = aw_valid & axi_rsp_i.aw_ready;
  assign w_hs  = w_valid & axi_rsp_i.w_ready;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d   = obi_req_i.a.we ? WR : RD_A;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WB;
      end
      WB: begin
        if (axi_rsp_i.b_valid) begin
          err_d   = axi_rsp_i.b.resp[1];
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_A: begin
        if (axi_rsp_i.ar_ready) state_d = RD_R;
      end
      RD_R: begin
        if (axi_rsp_i.r_valid) begin
          rdata_d = axi_rsp_i.r.data;
          err_d   = axi_rsp_i.r.resp[1];
          state_d = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aid_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (gnt) begin
        addr_q  <= obi_req_i.a.addr;
        be_q    <= obi_req_i.a.be;
        wdata_q <= obi_req_i.a.wdata;
        aid_q   <= obi_req_i.a.aid;
      end
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID;
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = 3'd2;
    axi_req_o.aw.burst = AXI_BURST_INCR;
    axi_req_o.aw.cache = AXI_CACHE;
    axi_req_o.aw_valid = aw_valid;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.b_ready  = (state_q == WB);
    axi_req_o.ar.id    = AXI_ID;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = 3'd2;
    axi_req_o.ar.burst = AXI_BURST_INCR;
    axi_req_o.ar.cache = AXI_CACHE;
    axi_req_o.ar_valid = (state_q == RD_A);
    axi_req_o.r_ready  = (state_q == RD_R);
  end

  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = gnt;
    obi_rsp_o.rvalid  = (state_q == RSP);
    obi_rsp_o.r.rdata = rdata_q;
    obi_rsp_o.r.rid   = aid_q;
    obi_rsp_o.r.err   = err_q;
  end

  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user,
                        axi_rsp_i.b.resp[0], axi_rsp_i.r.id,
                        axi_rsp_i.r.resp[0], axi_rsp_i.r.last,
                        axi_rsp_i.r.user};

endmodule
